// File: rtl/park_pkg.sv
// Shared types and sizing for the parking allocator.
// Holds the FSM state enum, the spot count and a free-spot counting helper.
package park_pkg;

  localparam int NUM_SPOTS = 8;
  localparam int SPOT_W    = 3;

  typedef enum logic [1:0] {
    IDLE,
    ALLOC,
    GATE
  } park_state_t;

  function automatic logic [3:0] count_free(input logic [NUM_SPOTS-1:0] map);
    logic [3:0] cnt;
    cnt = '0;
    for (int i = 0; i < NUM_SPOTS; i++) begin
      cnt = cnt + 4'(~map[i]);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/gate_timer.sv
// Entry barrier timer: holds gate_open high for GATE_CYCLES cycles after start.
// busy means the gate is open and stays open for at least one more cycle.
module gate_timer #(
  parameter int GATE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  output logic busy,
  output logic gate_open
);

  logic [3:0] remaining;

  always_ff @(posedge clk) begin
    if (reset) begin
      gate_open <= 1'b0;
      remaining <= '0;
    end else if (start) begin
      gate_open <= 1'b1;
      remaining <= 4'(GATE_CYCLES - 1);
    end else if (gate_open) begin
      if (remaining == '0) begin
        gate_open <= 1'b0;
      end else begin
        remaining <= remaining - 4'd1;
      end
    end
  end

  assign busy = gate_open && (remaining != '0);

endmodule

// File: rtl/park_allocator.sv
// Parking lot allocator: admits cars into the lowest free spot, drives the
// entry barrier, tracks occupancy and handles departures in every state.
module park_allocator
  import park_pkg::*;
#(
  parameter int GATE_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 entry,
  input  logic [SPOT_W-1:0]    park_number,
  input  logic                 exit_req,
  input  logic [SPOT_W-1:0]    exit_number,
  output logic [NUM_SPOTS-1:0] parking_capacity,
  output logic                 gate_open,
  output logic                 assigned_valid,
  output logic [SPOT_W-1:0]    assigned_number,
  output logic                 full,
  output logic [3:0]           free_count,
  output logic                 entry_rejected,
  output logic                 exit_err
);

  park_state_t          state;
  park_state_t          next_state;
  logic                 entry_q;
  logic                 entry_event;
  logic                 pending;
  logic                 pending_next;
  logic                 admit;
  logic                 reject;
  logic                 timer_start;
  logic                 timer_busy;
  logic                 exit_hit;
  logic [NUM_SPOTS-1:0] set_mask;
  logic [NUM_SPOTS-1:0] clr_mask;

  assign full        = &parking_capacity;
  assign free_count  = count_free(parking_capacity);
  assign entry_event = entry && !entry_q;

  // The car is booked on the IDLE->ALLOC edge so that assigned_valid and the
  // bitmap bit both appear in the ALLOC cycle; a pending car goes first and a
  // simultaneous new event takes its place in the one-deep pending slot.
  always_comb begin
    next_state   = state;
    pending_next = pending;
    admit        = 1'b0;
    reject       = 1'b0;
    timer_start  = 1'b0;
    case (state)
      IDLE: begin
        if (entry_event || pending) begin
          if (!full) begin
            admit        = 1'b1;
            next_state   = ALLOC;
            pending_next = pending && entry_event;
          end else begin
            reject       = 1'b1;
            pending_next = 1'b0;
          end
        end
      end
      ALLOC: begin
        timer_start = 1'b1;
        next_state  = GATE;
        if (entry_event) pending_next = 1'b1;
      end
      GATE: begin
        if (entry_event) pending_next = 1'b1;
        if (!timer_busy) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    exit_hit = exit_req && parking_capacity[exit_number];
    set_mask = admit    ? (NUM_SPOTS'(1) << park_number) : '0;
    clr_mask = exit_hit ? (NUM_SPOTS'(1) << exit_number) : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      pending <= 1'b0;
      entry_q <= 1'b0;
    end else begin
      state   <= next_state;
      pending <= pending_next;
      entry_q <= entry;
    end
  end

  // A set and a clear on the same spot cannot both be legal: the spot is free,
  // so the clear is already refused and flagged as an exit error.
  always_ff @(posedge clk) begin
    if (reset) begin
      parking_capacity <= '0;
      assigned_valid   <= 1'b0;
      assigned_number  <= '0;
      entry_rejected   <= 1'b0;
      exit_err         <= 1'b0;
    end else begin
      parking_capacity <= (parking_capacity & ~clr_mask) | set_mask;
      assigned_valid   <= admit;
      entry_rejected   <= reject;
      exit_err         <= exit_req && !exit_hit;
      if (admit) assigned_number <= park_number;
    end
  end

  gate_timer #(
    .GATE_CYCLES(GATE_CYCLES)
  ) u_gate_timer (
    .clk      (clk),
    .reset    (reset),
    .start    (timer_start),
    .busy     (timer_busy),
    .gate_open(gate_open)
  );

endmodule

// File: tb/tb_park_allocator.sv
// Self-checking bench for park_allocator: directed scenarios with literal
// expectations plus randomized traffic compared against a cycle-level model.
module tb_park_allocator;

  localparam int G = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       entry;
  logic [2:0] park_number;
  logic       exit_req;
  logic [2:0] exit_number;
  logic [7:0] parking_capacity;
  logic       gate_open;
  logic       assigned_valid;
  logic [2:0] assigned_number;
  logic       full;
  logic [3:0] free_count;
  logic       entry_rejected;
  logic       exit_err;

  int total = 0;
  int bad   = 0;

  // Model: occupancy, pending car, and cycles left until the block is idle again.
  logic [7:0] m_cap;
  logic       m_pending;
  logic       m_prev_entry;
  logic       m_av;
  logic       m_rej;
  logic       m_err;
  logic [2:0] m_anum;
  int         m_busy_left;

  always #5 clk = ~clk;

  park_allocator #(.GATE_CYCLES(G)) dut (
    .clk             (clk),
    .reset           (reset),
    .entry           (entry),
    .park_number     (park_number),
    .exit_req        (exit_req),
    .exit_number     (exit_number),
    .parking_capacity(parking_capacity),
    .gate_open       (gate_open),
    .assigned_valid  (assigned_valid),
    .assigned_number (assigned_number),
    .full            (full),
    .free_count      (free_count),
    .entry_rejected  (entry_rejected),
    .exit_err        (exit_err)
  );

  function automatic logic [2:0] lowestFree(input logic [7:0] map);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (map[i] === 1'b0) idx = 3'(i);
    end
    return idx;
  endfunction

  task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // An admitted car occupies G+1 busy cycles: one booking cycle, then G gate cycles.
  task automatic modelStep();
    logic       ev;
    logic [7:0] setm;
    logic [7:0] clrm;
    if (reset) begin
      m_cap = 8'h00; m_pending = 1'b0; m_prev_entry = 1'b0; m_av = 1'b0;
      m_rej = 1'b0;  m_err = 1'b0;     m_anum = 3'd0;       m_busy_left = 0;
      return;
    end
    ev = entry && !m_prev_entry;
    m_prev_entry = entry;
    setm = 8'h00;
    clrm = 8'h00;
    m_av = 1'b0;
    m_rej = 1'b0;
    if (m_busy_left == 0) begin
      if (ev || m_pending) begin
        if (m_cap != 8'hFF) begin
          m_av = 1'b1;
          m_anum = park_number;
          setm[park_number] = 1'b1;
          m_pending = m_pending && ev;
          m_busy_left = G + 1;
        end else begin
          m_rej = 1'b1;
          m_pending = 1'b0;
        end
      end
    end else begin
      if (ev) m_pending = 1'b1;
      m_busy_left--;
    end
    m_err = exit_req && !m_cap[exit_number];
    if (exit_req && m_cap[exit_number]) clrm[exit_number] = 1'b1;
    m_cap = (m_cap & ~clrm) | setm;
  endtask

  task automatic checkOutput();
    checkValue("parking_capacity", 32'(parking_capacity), 32'(m_cap));
    checkValue("gate_open", 32'(gate_open), 32'(m_busy_left >= 1 && m_busy_left <= G));
    checkValue("assigned_valid", 32'(assigned_valid), 32'(m_av));
    checkValue("assigned_number", 32'(assigned_number), 32'(m_anum));
    checkValue("full", 32'(full), 32'(m_cap == 8'hFF));
    checkValue("free_count", 32'(free_count), 32'(8 - $countones(m_cap)));
    checkValue("entry_rejected", 32'(entry_rejected), 32'(m_rej));
    checkValue("exit_err", 32'(exit_err), 32'(m_err));
  endtask

  task automatic applyStimulus(input logic r, input logic e, input logic xr, input logic [2:0] xn);
    reset       = r;
    entry       = e;
    exit_req    = xr;
    exit_number = xn;
    park_number = lowestFree(m_cap);
    @(posedge clk);
    modelStep();
    @(negedge clk);
    checkOutput();
  endtask

  task automatic fillSpots(input int n);
    for (int k = 0; k < n; k++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 3'd0);
      repeat (7) applyStimulus(1'b0, 1'b0, 1'b0, 3'd0);
    end
  endtask

  initial begin
    logic found;
    logic e;
    reset = 1'b1; entry = 1'b0; exit_req = 1'b0; exit_number = 3'd0; park_number = 3'd0;
    m_cap = 8'h00;

    // First admission timing after reset
    applyStimulus(1'b1, 1'b0, 1'b0, 3'd0);
    checkValue("reset_cap", 32'(parking_capacity), 32'h00);
    checkValue("reset_gate", 32'(gate_open), 32'h0);
    applyStimulus(1'b0, 1'b0, 1'b0, 3'd0);
    applyStimulus(1'b0, 1'b1, 1'b0, 3'd0);
    checkValue("first_valid", 32'(assigned_valid), 32'h1);
    checkValue("first_number", 32'(assigned_number), 32'h0);
    checkValue("first_cap", 32'(parking_capacity), 32'h01);
    for (int i = 0; i < G; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 3'd0);
      checkValue("gate_high", 32'(gate_open), 32'h1);
    end
    applyStimulus(1'b0, 1'b1, 1'b0, 3'd0);
    checkValue("gate_closed", 32'(gate_open), 32'h0);

    // Fill the lot, then a ninth car is turned away
    applyStimulus(1'b1, 1'b0, 1'b0, 3'd0);
    fillSpots(8);
    checkValue("fill_cap", 32'(parking_capacity), 32'hFF);
    checkValue("fill_full", 32'(full), 32'h1);
    checkValue("fill_free", 32'(free_count), 32'h0);
    applyStimulus(1'b0, 1'b1, 1'b0, 3'd0);
    checkValue("ninth_rejected", 32'(entry_rejected), 32'h1);
    checkValue("ninth_cap", 32'(parking_capacity), 32'hFF);
    applyStimulus(1'b0, 1'b0, 1'b0, 3'd0);
    checkValue("reject_one_cycle", 32'(entry_rejected), 32'h0);

    // Legal and illegal departures
    applyStimulus(1'b1, 1'b0, 1'b0, 3'd0);
    fillSpots(4);
    checkValue("four_cap", 32'(parking_capacity), 32'h0F);
    applyStimulus(1'b0, 1'b0, 1'b1, 3'd2);
    checkValue("exit2_cap", 32'(parking_capacity), 32'h0B);
    checkValue("exit2_err", 32'(exit_err), 32'h0);
    applyStimulus(1'b0, 1'b0, 1'b1, 3'd5);
    checkValue("exit5_err", 32'(exit_err), 32'h1);
    checkValue("exit5_cap", 32'(parking_capacity), 32'h0B);

    // A second car arriving during the gate window waits, then gets spot 1
    applyStimulus(1'b1, 1'b0, 1'b0, 3'd0);
    applyStimulus(1'b0, 1'b1, 1'b0, 3'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 3'd0);
    applyStimulus(1'b0, 1'b1, 1'b0, 3'd0);
    found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 3'd0);
      if (assigned_valid === 1'b1) found = 1'b1;
    end
    checkValue("pending_admitted", 32'(found), 32'h1);
    checkValue("pending_number", 32'(assigned_number), 32'h1);
    checkValue("pending_cap", 32'(parking_capacity), 32'h03);

    // Booking and departure on the same spot, then reset mid-gate
    applyStimulus(1'b1, 1'b0, 1'b0, 3'd0);
    fillSpots(8);
    applyStimulus(1'b0, 1'b0, 1'b1, 3'd0);
    checkValue("fe_cap", 32'(parking_capacity), 32'hFE);
    applyStimulus(1'b0, 1'b1, 1'b1, 3'd0);
    checkValue("collide_cap", 32'(parking_capacity), 32'hFF);
    checkValue("collide_err", 32'(exit_err), 32'h1);
    checkValue("collide_valid", 32'(assigned_valid), 32'h1);
    applyStimulus(1'b0, 1'b0, 1'b0, 3'd0);
    checkValue("collide_gate", 32'(gate_open), 32'h1);
    applyStimulus(1'b1, 1'b0, 1'b0, 3'd0);
    checkValue("abort_gate", 32'(gate_open), 32'h0);
    checkValue("abort_cap", 32'(parking_capacity), 32'h00);

    // Randomized traffic against the model
    applyStimulus(1'b1, 1'b0, 1'b0, 3'd0);
    e = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 2) == 0) e = ~e;
      applyStimulus($urandom_range(0, 299) == 0, e, $urandom_range(0, 3) == 0,
                    3'($urandom_range(0, 7)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/park_allocator.md
PARK_ALLOCATOR -- requirements
Module: park_allocator

Interface
REQ-001 SHALL have parameter GATE_CYCLES, default 4: number of cycles gate_open stays high per admitted car, legal range 1..15.
REQ-002 SHALL use one clock and a reset that is synchronous and active-high; ports in REQ-003 to REQ-014, in that order.
REQ-003 clk  input  1  rising-edge system clock.
REQ-004 reset  input  1  synchronous active-high reset.
REQ-005 entry  input  1  entry sensor level; car present at entry gate.
REQ-006 park_number  input  3  lowest free spot index from the upstream entry_park stage; valid only when full=0.
REQ-007 exit_req  input  1  single-cycle pulse; a car leaves spot exit_number.
REQ-008 exit_number  input  3  spot index being vacated; sampled when exit_req=1.
REQ-009 parking_capacity  output  8  registered occupancy bitmap; bit i=1 means spot i occupied; drives entry_park.
REQ-010 gate_open  output  1  entry barrier open command.
REQ-011 assigned_valid  output  1  one-cycle pulse; assigned_number is valid.
REQ-012 assigned_number  output  3  spot given to the admitted car; holds until the next assignment.
REQ-013 full  output  1  combinational; 1 when parking_capacity == 8'hFF.
REQ-014 free_count  output  4  combinational count of zero bits in parking_capacity, 0..8; entry_rejected and exit_err pulses are listed under Function.

Function
REQ-015 SHALL detect an entry event as entry=1 with the previous cycle's registered entry=0; a held level SHALL produce one event only.
REQ-016 SHALL implement FSM states IDLE, ALLOC, GATE.
REQ-017 IDLE: on an entry event or a set pending flag with full=0, SHALL go to ALLOC and clear pending.
REQ-018 IDLE: on an entry event with full=1, SHALL pulse entry_rejected (1-bit output) for one cycle, stay in IDLE, and leave the bitmap unchanged.
REQ-019 ALLOC (one cycle): SHALL set bit park_number in parking_capacity, latch assigned_number=park_number, and pulse assigned_valid in the same cycle; next state GATE.
REQ-020 GATE: gate_open SHALL be 1 for exactly GATE_CYCLES cycles, starting the cycle after ALLOC, then return to IDLE with gate_open=0.
REQ-021 An entry event arriving in ALLOC or GATE SHALL set a one-deep pending flag; further events while pending is set SHALL be dropped.
REQ-022 Entry latency SHALL be: event at cycle N gives assigned_valid at N+1 and gate_open from N+2 to N+1+GATE_CYCLES.
REQ-023 Exit SHALL be processed in every FSM state: if exit_req=1 and bit exit_number=1, that bit SHALL clear at the next edge; otherwise exit_err (1-bit output) SHALL pulse for one cycle and the bitmap SHALL be unchanged.
REQ-024 If exit and ALLOC occur in the same cycle on different bits, both updates SHALL apply; if they target the same bit, the set SHALL apply and exit_err SHALL pulse.
REQ-025 If the last free spot is released while pending=1 and full=1, the pending car SHALL be admitted on return to IDLE; a pending car at full=1 in IDLE SHALL be rejected as in REQ-018.

Reset
REQ-026 With reset=1 at a clock edge, the block SHALL set parking_capacity=0, assigned_number=0, assigned_valid=0, gate_open=0, entry_rejected=0, exit_err=0, pending=0, gate counter=0, registered entry=0, and state=IDLE.
REQ-027 Reset during ALLOC or GATE SHALL abort the operation; gate_open SHALL be 0 the cycle after reset.

Structure
REQ-028 Shared package park_pkg SHALL hold the state enum, NUM_SPOTS=8, and SPOT_W=3.
REQ-029 The gate counter SHALL be one sub-module, gate_timer, with inputs start and GATE_CYCLES and outputs busy and gate_open.

Verification
REQ-030 Reset, then entry rising at cycle 2 -> assigned_valid at 3 with assigned_number=0, parking_capacity=8'h01, gate_open at cycles 4-7 (GATE_CYCLES=4).
REQ-031 Eight spaced entries -> bitmap 8'hFF, full=1, free_count=0; ninth entry -> entry_rejected pulse, bitmap unchanged.
REQ-032 Bitmap 8'h0F, exit_req with exit_number=2 -> 8'h0B; exit_req with exit_number=5 -> exit_err pulse, 8'h0B retained.
REQ-033 Second entry edge during GATE -> pending; on return to IDLE, next ALLOC assigns the next free spot.
REQ-034 Bitmap 8'hFE with ALLOC and exit_req on spot 0 in the same cycle -> bitmap 8'hFF and exit_err=1; reset asserted in GATE -> gate_open=0 and bitmap 0 next cycle.
